// File: rtl/servo_ramp_if.sv
// Command port bundle for the servo ramp scheduler: valid/ready handshake,
// target channel/width and the error pulse for out-of-range channels.
interface servo_ramp_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic [15:0] cmd_width_us;
    logic        cmd_err;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_width_us,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_width_us,
        output cmd_ready,
        output cmd_err
    );
endinterface

// File: rtl/servo_ramp_scheduler.sv
// Rate-limited servo target scheduler. Once per update tick a single step
// unit walks all channels, moving each width toward its clamped target.
// Optional feature macro: SERVO_RAMP_EN (defined = slew by at most STEP_US
// per sweep; undefined = width jumps straight to target on each sweep).
module servo_ramp_scheduler #(
    parameter int NUM_CH    = 5,
    parameter int CLK_HZ    = 50_000_000,
    parameter int UPDATE_HZ = 200,
    parameter int STEP_US   = 10,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int CENTER_US = 1500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_ramp_if.slave          cmd,
    output logic [16*NUM_CH-1:0] width_us,
    output logic [NUM_CH-1:0]    at_target,
    output logic                 busy
);

    localparam int DIV   = CLK_HZ / UPDATE_HZ;
    localparam int CNT_W = $clog2(DIV);

    // The sweep must finish before the next tick, and the channel index is 3 bits.
    if (DIV <= NUM_CH + 1 || NUM_CH < 1 || NUM_CH > 8 || STEP_US < 1) begin : g_bad_params
        $error("servo_ramp_scheduler: invalid parameter set");
    end

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_nxt;
    logic [2:0]       k, k_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic             accept;
    logic             ch_ok;
    logic             err;
    logic [15:0]      width  [NUM_CH];
    logic [15:0]      target [NUM_CH];

    function automatic logic [15:0] clamp_us(input logic [15:0] v);
        if (v < 16'(MIN_US))      return 16'(MIN_US);
        else if (v > 16'(MAX_US)) return 16'(MAX_US);
        else                      return v;
    endfunction

`ifdef SERVO_RAMP_EN
    localparam logic signed [16:0] STEP_S = 17'(STEP_US);

    // Both operands lie in [MIN_US, MAX_US] and the step never overshoots,
    // so the result stays inside the clamp range.
    function automatic logic [15:0] ramp_step(input logic [15:0] cur, input logic [15:0] tgt);
        logic signed [16:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)       return cur + 16'(STEP_US);
        else if (diff < -STEP_S) return cur - 16'(STEP_US);
        else                     return tgt;
    endfunction
`endif

    assign tick          = (div_cnt == CNT_W'(DIV - 1));
    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == SWEEP);
    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign ch_ok         = (int'(cmd.cmd_ch) < NUM_CH);
    assign cmd.cmd_err   = err;

    // Free-running update-tick divider, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + CNT_W'(1);
    end

    // FSM state and sweep channel index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Next-state logic: one tick starts a sweep of exactly NUM_CH cycles.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            IDLE: begin
                k_nxt = '0;
                if (tick) state_nxt = SWEEP;
            end
            SWEEP: begin
                k_nxt = k + 3'd1;
                if (k == 3'(NUM_CH - 1)) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error pulse for accepted commands addressing a nonexistent channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= accept && !ch_ok;
    end

    // Target capture on handshake and width update for the channel being swept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                width[i]  <= 16'(CENTER_US);
                target[i] <= 16'(CENTER_US);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && cmd.cmd_ch == 3'(i))
                    target[i] <= clamp_us(cmd.cmd_width_us);
                if (state == SWEEP && k == 3'(i)) begin
`ifdef SERVO_RAMP_EN
                    width[i] <= ramp_step(width[i], target[i]);
`else
                    width[i] <= target[i];
`endif
                end
            end
        end
    end

    // Pack widths onto the output bus and flag channels that have arrived.
    always_comb begin
        width_us  = '0;
        at_target = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            width_us[16*i +: 16] = width[i];
            at_target[i]         = (width[i] == target[i]);
        end
    end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Testbench for servo_ramp_scheduler: directed scenarios plus random commands,
// checked each cycle against a sweep-level behavioural model.
module tb_servo_ramp_scheduler;

    localparam int NUM_CH = 5;
    localparam int DIV    = 10;
    localparam int STEP   = 10;
    localparam int MIN    = 1000;
    localparam int MAX    = 2000;
    localparam int CTR    = 1500;

    logic clk = 1'b0;
    logic rst_n;
    logic [16*NUM_CH-1:0] width_us;
    logic [NUM_CH-1:0]    at_target;
    logic                 busy;

    servo_ramp_if cmd_bus();

    servo_ramp_scheduler #(
        .NUM_CH(NUM_CH), .CLK_HZ(1000), .UPDATE_HZ(100), .STEP_US(STEP),
        .MIN_US(MIN), .MAX_US(MAX), .CENTER_US(CTR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_bus),
        .width_us(width_us), .at_target(at_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_w [NUM_CH];
    int m_t [NUM_CH];
    int cyc;
    bit m_err;
    bit last_accepted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < MIN) return MIN;
        if (v > MAX) return MAX;
        return v;
    endfunction

    function automatic int next_width(input int w, input int t);
`ifdef SERVO_RAMP_EN
        if (t - w > STEP) return w + STEP;
        if (w - t > STEP) return w - STEP;
`endif
        return t;
    endfunction

    // Tick is seen at count DIV-1; the following NUM_CH cycles sweep channels 0..NUM_CH-1.
    function automatic bit sweeping(input int c);
        return (c >= DIV) && ((c % DIV) < NUM_CH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_w[i] = CTR;
            m_t[i] = CTR;
        end
        cyc   = 0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs();
        bit sw;
        logic [NUM_CH-1:0] exp_at;
        sw = sweeping(cyc);
        check_eq("cmd_ready", cmd_bus.cmd_ready, !sw);
        check_eq("busy", busy, sw);
        check_eq("cmd_err", cmd_bus.cmd_err, m_err);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_at[i] = (m_w[i] == m_t[i]);
            check_eq($sformatf("width%0d", i), width_us[16*i +: 16], m_w[i]);
        end
        check_eq("at_target", at_target, exp_at);
    endtask

    // Advance one clock: the model consumes this cycle's inputs at the edge,
    // outputs are compared at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        last_accepted = 1'b0;
        m_err = 1'b0;
        if (sweeping(cyc)) begin
            int k;
            k = cyc % DIV;
            m_w[k] = next_width(m_w[k], m_t[k]);
        end else if (cmd_bus.cmd_valid) begin
            last_accepted = 1'b1;
            if (cmd_bus.cmd_ch < NUM_CH) m_t[cmd_bus.cmd_ch] = clampv(int'(cmd_bus.cmd_width_us));
            else m_err = 1'b1;
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int ch, input int w, output int ncyc);
        cmd_bus.cmd_valid    = 1'b1;
        cmd_bus.cmd_ch       = 3'(ch);
        cmd_bus.cmd_width_us = 16'(w);
        ncyc = 0;
        do begin
            cycle();
            ncyc++;
        end while (!last_accepted && ncyc < 3 * DIV);
        if (!last_accepted) check_eq("accept_timeout", 0, 1);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < 3 * DIV) begin
            cycle();
            n++;
        end
        check_eq("busy_seen", busy, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        int n;
        cmd_bus.cmd_valid    = 1'b0;
        cmd_bus.cmd_ch       = '0;
        cmd_bus.cmd_width_us = '0;
        rst_n = 1'b1;
        @(negedge clk);
        apply_reset();

        // Idle: reset state and periodic busy pattern.
        run(3 * DIV);

        // Small move on ch2.
        send(2, 1600, n);
        run(12 * DIV);
        check_eq("ch2_final", width_us[32 +: 16], 1600);

        // Clamp above range, full slew down, then a tiny move.
        send(0, 2500, n);
        run(52 * DIV);
        check_eq("ch0_clamped", width_us[0 +: 16], 2000);
        send(0, 1000, n);
        run(101 * DIV);
        check_eq("ch0_min", width_us[0 +: 16], 1000);
        send(0, 1003, n);
        run(2 * DIV);
        check_eq("ch0_snap", width_us[0 +: 16], 1003);

        // Command held from the first sweep cycle is stalled then accepted.
        wait_busy();
        send(4, 1200, n);
        check_eq("stall_cycles", n, NUM_CH + 1);
        run(4 * DIV);

        // Out-of-range channel.
        send(6, 1700, n);
        check_eq("err_pulse", cmd_bus.cmd_err, 1);
        cycle();
        check_eq("err_clear", cmd_bus.cmd_err, 0);
        run(2 * DIV);

        // Asynchronous reset in the middle of a sweep.
        send(1, 1800, n);
        run(32 * DIV);
        check_eq("ch1_final", width_us[16 +: 16], 1800);
        wait_busy();
        run(2);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_CH; i++)
            check_eq($sformatf("async_width%0d", i), width_us[16*i +: 16], CTR);
        check_eq("async_busy", busy, 0);
        check_eq("async_at_target", at_target, {NUM_CH{1'b1}});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();

        // ch3 toward 1900 (jump or slew depending on build).
        send(3, 1900, n);
        run(DIV + NUM_CH + 2);

        // Random commands, including invalid channels and out-of-range widths.
        for (int it = 0; it < 300; it++) begin
            run($urandom_range(0, 12));
            send($urandom_range(0, 7), $urandom_range(900, 2600), n);
        end
        run(20 * DIV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_ramp_scheduler.md
# servo_ramp_scheduler

Rate-limited motion scheduler for the arm's servo PWM channels. Accepts per-channel target pulse widths over a valid/ready command port and, once per update tick, walks a single shared step unit across all channels, moving each channel's `width_us` toward its target. The per-channel widths feed the `servo_pwm` generators directly, so joints slew smoothly instead of snapping to new positions.

## Interface
- `NUM_CH`, 5: number of servo channels, 1..8.
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `UPDATE_HZ`, 200: sweep rate. `DIV = CLK_HZ/UPDATE_HZ` and must satisfy `DIV > NUM_CH + 1`.
- `STEP_US`, 10: maximum width change per channel per sweep, in µs.
- `MIN_US`, 1000: lower clamp for targets, in µs.
- `MAX_US`, 2000: upper clamp for targets, in µs.
- `CENTER_US`, 1500: reset width and reset target, in µs.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  a command is present.
- `cmd_ready`  out  1  the block can accept a command.
- `cmd_ch`  in  3  target channel index.
- `cmd_width_us`  in  16  requested pulse width, in µs.
- `cmd_err`  out  1  one-cycle pulse when an accepted command has `cmd_ch >= NUM_CH`.
- `width_us`  out  16*NUM_CH  current width per channel. Channel i occupies bits [16i+15:16i].
- `at_target`  out  NUM_CH  bit i is set when channel i's width equals its target.
- `busy`  out  1  high while in SWEEP.

## Operation
- Tick divider:
  - The counter runs 0..DIV-1 and wraps.
  - `tick` is an internal signal, high in the cycle where the count equals DIV-1.
- State machine has two states, IDLE and SWEEP:
  - IDLE → SWEEP on `tick`, with channel index `k` set to 0.
  - SWEEP processes channel `k` in each cycle. After `k = NUM_CH-1` it returns to IDLE.
- Command handling:
  - `cmd_ready` = (state == IDLE).
  - Handshake is `cmd_valid & cmd_ready`.
  - On acceptance, target[`cmd_ch`] ← clamp(`cmd_width_us`, MIN_US, MAX_US).
  - If `cmd_ch >= NUM_CH`, the command is accepted and dropped, no target changes, and `cmd_err` pulses in the next cycle.
  - A later command to the same channel overwrites its target. There is no queue.
- Sweep step for channel k, with d = target − width:
  - If |d| ≤ STEP_US: width ← target.
  - Otherwise: width ← width ± STEP_US, in the direction of d.
  - The difference uses a 17-bit signed intermediate. The result never leaves [MIN_US, MAX_US].
  - `at_target[k]` is updated in the same cycle from the new width.
- A command accepted in a cycle where `cmd_ch` ≠ the channel being swept updates `at_target` for `cmd_ch` in the next cycle.

## Timing
- Reset values:
  - All widths = CENTER_US.
  - All targets = CENTER_US.
  - `at_target` = all ones.
  - `cmd_ready` = 1, `busy` = 0, `cmd_err` = 0.
  - State = IDLE, divider = 0.
- Reset mid-SWEEP aborts the sweep immediately and restores all reset values, including widths.
- Command in the tick cycle: the command is accepted (state is still IDLE), and the new target is used by the sweep that starts next cycle.
- SWEEP lasts exactly NUM_CH cycles. `busy` is high and `cmd_ready` is low for exactly those cycles.
- Latency: channel k's `width_us` changes k+1 cycles after the tick cycle.
- Worst-case full slew from MIN_US to MAX_US takes ceil((MAX_US−MIN_US)/STEP_US) sweeps; 100 sweeps at the default settings.
- A `cmd_valid` held during SWEEP is stalled, not lost. It is accepted in the first IDLE cycle.

## Configuration
- `SERVO_RAMP_EN`:
  - Defined: widths slew by at most STEP_US per sweep, as described above.
  - Not defined: the sweep sets width ← target directly. Tick sequencing, the handshake and `at_target` are unchanged, and the STEP_US parameter is ignored.

## Test plan
Test parameters: CLK_HZ=1000, UPDATE_HZ=100 (DIV=10), NUM_CH=5, `SERVO_RAMP_EN` defined unless stated.
- After reset: all widths = 1500, `at_target` = 5'b11111, `cmd_ready` = 1, and `busy` rises for 5 cycles every 10 cycles.
- Command ch2 = 1600: `at_target[2]` = 0 the next cycle. Ch2 width reads 1510, 1520, … and reaches 1600 after 10 sweeps, then `at_target[2]` = 1. The other channels stay at 1500.
- Command ch0 = 2500: clamped to 2000. Ch0 reaches 2000 after 50 sweeps. Command ch0 = 1003 from 1000: the width snaps to 1003 in one sweep.
- Hold `cmd_valid` high with ch4 = 1200 starting in the first SWEEP cycle: `cmd_ready` stays low for 5 cycles, then the handshake completes. Ch4 first changes to 1490 in the following sweep.
- Command ch6 = 1700: accepted, `cmd_err` pulses for one cycle, and no width or target changes.
- Assert `rst_n` low mid-sweep with ch1 at 1800: all widths return to 1500 asynchronously. With `SERVO_RAMP_EN` undefined, ch3 = 1900 jumps to 1900 at the next sweep.
